fifo_burst_writer: RTL and testbench

Write-domain traffic source that acts as the producer for the async FIFO write port.
- On command, it generates a burst of WIDTH-bit words using a selectable pattern and presents them on wr_rq/wdata.
- It obeys the FIFO's full back-pressure and reports completion, stall count and an XOR checksum of every word the FIFO accepted.
- It runs entirely on w_clk, so its outputs connect directly to the FIFO write port.

---
 rtl/fifo_burst_writer.sv | 171 +++++++++++++++++
 tb/tb_fifo_burst_writer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_burst_writer.sv
// rtl/fifo_burst_writer.sv - burst traffic source driving an async FIFO write port
//
// Ports:
//   w_clk, rst_n             write-domain clock, asynchronous active-low reset
//   start, burst_len, seed,  burst command; sampled only while idle
//   mode                     pattern: 0 incr, 1 LFSR, 2 constant, 3 seed/~seed
//   abort                    end the running burst early
//   full                     FIFO back-pressure
//   wr_rq, wdata             FIFO write request and data
//   busy, done, aborted      status: active, one-cycle completion, ended by abort
//   words_sent, checksum     accepted-word count and XOR of accepted words
//   stall_cnt                cycles spent requesting against full, saturating

module fifo_burst_writer #(
    parameter int               WIDTH = 4,
    parameter int               LEN_W = 4,
    parameter logic [WIDTH-1:0] TAPS  = 4'b1100
) (
    input  logic             w_clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] burst_len,
    input  logic [WIDTH-1:0] seed,
    input  logic [1:0]       mode,
    input  logic             abort,
    input  logic             full,
    output logic             wr_rq,
    output logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [LEN_W-1:0] words_sent,
    output logic [WIDTH-1:0] checksum,
    output logic [7:0]       stall_cnt
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           state_q, state_nxt;
    logic [1:0]       mode_q, mode_nxt;
    logic [LEN_W-1:0] remaining_q, remaining_nxt;

    logic             wr_rq_nxt, busy_nxt, done_nxt, aborted_nxt;
    logic [WIDTH-1:0] wdata_nxt, checksum_nxt;
    logic [LEN_W-1:0] words_sent_nxt;
    logic [7:0]       stall_cnt_nxt;

    logic accept;
    logic last_word;

    assign accept    = wr_rq & ~full;
    assign last_word = (remaining_q == LEN_W'(1));

    function automatic logic [WIDTH-1:0] next_word(input logic [1:0] m,
                                                   input logic [WIDTH-1:0] w);
        logic [WIDTH-1:0] r;
        case (m)
            2'd0:    r = w + WIDTH'(1);
            2'd1:    r = {w[WIDTH-2:0], ^(w & TAPS)};
            2'd2:    r = w;
            default: r = ~w;
        endcase
        return r;
    endfunction

    // State and all registered outputs.
    always_ff @(posedge w_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            mode_q      <= 2'd0;
            remaining_q <= '0;
            wr_rq       <= 1'b0;
            wdata       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            aborted     <= 1'b0;
            words_sent  <= '0;
            checksum    <= '0;
            stall_cnt   <= '0;
        end else begin
            state_q     <= state_nxt;
            mode_q      <= mode_nxt;
            remaining_q <= remaining_nxt;
            wr_rq       <= wr_rq_nxt;
            wdata       <= wdata_nxt;
            busy        <= busy_nxt;
            done        <= done_nxt;
            aborted     <= aborted_nxt;
            words_sent  <= words_sent_nxt;
            checksum    <= checksum_nxt;
            stall_cnt   <= stall_cnt_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            S_IDLE:
                if (start)
                    state_nxt = (burst_len != '0) ? S_WRITE : S_DONE;
            S_WRITE:
                if (abort || (accept && last_word))
                    state_nxt = S_DONE;
            S_DONE:
                state_nxt = S_IDLE;
            default:
                state_nxt = S_IDLE;
        endcase
    end

    // Output / datapath next values.
    always_comb begin
        mode_nxt       = mode_q;
        remaining_nxt  = remaining_q;
        wr_rq_nxt      = wr_rq;
        wdata_nxt      = wdata;
        aborted_nxt    = aborted;
        words_sent_nxt = words_sent;
        checksum_nxt   = checksum;
        stall_cnt_nxt  = stall_cnt;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mode_nxt       = mode;
                    remaining_nxt  = burst_len;
                    words_sent_nxt = '0;
                    checksum_nxt   = '0;
                    stall_cnt_nxt  = '0;
                    aborted_nxt    = 1'b0;
                    if (burst_len != '0) begin
                        wr_rq_nxt = 1'b1;
                        // An all-zero LFSR state would lock up, so seed 0 becomes 1.
                        wdata_nxt = (mode == 2'd1 && seed == '0) ? WIDTH'(1) : seed;
                    end
                end
            end
            S_WRITE: begin
                if (accept) begin
                    checksum_nxt   = checksum ^ wdata;
                    words_sent_nxt = words_sent + LEN_W'(1);
                    remaining_nxt  = remaining_q - LEN_W'(1);
                    if (last_word)
                        wr_rq_nxt = 1'b0;
                    else
                        wdata_nxt = next_word(mode_q, wdata);
                end else if (wr_rq && full && stall_cnt != 8'hFF) begin
                    stall_cnt_nxt = stall_cnt + 8'd1;
                end
                // The FIFO still captured a word accepted on the abort edge,
                // so the accounting above stands.
                if (abort) begin
                    wr_rq_nxt   = 1'b0;
                    aborted_nxt = 1'b1;
                end
            end
            default: begin
                wr_rq_nxt = 1'b0;
            end
        endcase
    end

    assign done_nxt = (state_nxt == S_DONE);
    assign busy_nxt = (state_nxt != S_IDLE);

endmodule

// File: tb/tb_fifo_burst_writer.sv
// tb/tb_fifo_burst_writer.sv - self-checking bench for fifo_burst_writer

module tb_fifo_burst_writer;

    logic       w_clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [3:0] burst_len;
    logic [3:0] seed;
    logic [1:0] mode;
    logic       abort;
    logic       full;
    logic       wr_rq;
    logic [3:0] wdata;
    logic       busy;
    logic       done;
    logic       aborted;
    logic [3:0] words_sent;
    logic [3:0] checksum;
    logic [7:0] stall_cnt;

    int vectors     = 0;
    int miscompares = 0;

    fifo_burst_writer #(
        .WIDTH(4),
        .LEN_W(4),
        .TAPS (4'b1100)
    ) dut (
        .w_clk     (w_clk),
        .rst_n     (rst_n),
        .start     (start),
        .burst_len (burst_len),
        .seed      (seed),
        .mode      (mode),
        .abort     (abort),
        .full      (full),
        .wr_rq     (wr_rq),
        .wdata     (wdata),
        .busy      (busy),
        .done      (done),
        .aborted   (aborted),
        .words_sent(words_sent),
        .checksum  (checksum),
        .stall_cnt (stall_cnt)
    );

    always #5 w_clk = ~w_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // k-th word of a burst, from the pattern definitions.
    function automatic logic [3:0] exp_word(input logic [3:0] s, input logic [1:0] m, input int k);
        int w;
        case (m)
            2'd0: return s + 4'(k);
            2'd1: begin
                w = (s == 4'd0) ? 1 : int'(s);
                repeat (k) w = ((w << 1) & 15) | ($countones(w & 12) & 1);
                return 4'(w);
            end
            2'd2: return s;
            default: return (k % 2 == 1) ? ~s : s;
        endcase
    endfunction

    // Runs one burst against the model. abort_at: accept index (1-based) that
    // carries abort, 0 for none. Full is forced for stall_n cycles once stall_at
    // words are accepted, otherwise random with probability full_pct percent.
    task automatic run_burst(input logic [3:0] s, input logic [1:0] m, input int len,
                             input int abort_at, input int stall_at, input int stall_n,
                             input int full_pct, input bit noise);
        logic [3:0] csum;
        int         idx, stalls, stall_sat, cyc, forced_left;
        bit         seen, exp_ab, f, a;
        csum = 4'd0; idx = 0; stalls = 0; stall_sat = 0;
        seen = 1'b0; exp_ab = 1'b0; forced_left = stall_n;

        @(negedge w_clk);
        start = 1'b1; burst_len = 4'(len); seed = s; mode = m;
        full = 1'($urandom % 2); abort = 1'b0;
        @(negedge w_clk);
        start = 1'b0;
        for (cyc = 0; cyc < 600; cyc++) begin
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            check("wr_rq_active", wr_rq, 1);
            check("busy_active", busy, 1);
            check("wdata", wdata, exp_word(s, m, idx));
            a = 1'b0;
            if (stall_at == idx && forced_left > 0) begin
                f = 1'b1;
                forced_left--;
            end else if (abort_at > 0 && idx == abort_at - 1) begin
                f = 1'b0;
                a = 1'b1;
            end else begin
                f = ($urandom_range(99) < full_pct);
            end
            full = f; abort = a;
            if (noise) begin
                start = ($urandom % 3 == 0);
                burst_len = 4'($urandom); seed = 4'($urandom); mode = 2'($urandom);
            end
            if (!f) begin
                csum ^= exp_word(s, m, idx);
                idx++;
            end else begin
                stalls++;
                if (stall_sat < 255) stall_sat++;
            end
            if (a) exp_ab = 1'b1;
            @(negedge w_clk);
        end
        start = 1'b0; full = 1'b0; abort = 1'b0;
        check("done_seen", 32'(seen), 1);
        check("latency", cyc, idx + stalls);
        check("wr_rq_in_done", wr_rq, 0);
        check("busy_in_done", busy, 1);
        check("words_sent", words_sent, idx);
        check("checksum", checksum, csum);
        check("stall_cnt", stall_cnt, stall_sat);
        check("aborted", aborted, 32'(exp_ab));
        @(negedge w_clk);
        check("done_single", done, 0);
        check("busy_idle", busy, 0);
        @(negedge w_clk);
        check("words_sent_hold", words_sent, idx);
        check("checksum_hold", checksum, csum);
    endtask

    initial begin
        int m, s, len, ab;
        rst_n = 1'b1; start = 1'b0; burst_len = 4'd0; seed = 4'd0;
        mode = 2'd0; abort = 1'b0; full = 1'b0;
        #1 rst_n = 1'b0;
        #12;
        check("rst_wr_rq", wr_rq, 0);
        check("rst_wdata", wdata, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_stall", stall_cnt, 0);
        @(negedge w_clk);
        rst_n = 1'b1;

        // Increment pattern, no back-pressure.
        run_burst(4'd3, 2'd0, 5, 0, -1, 0, 0, 1'b0);
        check("t1_checksum", checksum, 4'h3);
        check("t1_words", words_sent, 5);
        check("t1_stall", stall_cnt, 0);

        // Wrap-around and LFSR, including seed-0 substitution.
        run_burst(4'd14, 2'd0, 4, 0, -1, 0, 0, 1'b0);
        check("t2_wrap_checksum", checksum, 4'h0);
        run_burst(4'd1, 2'd1, 4, 0, -1, 0, 0, 1'b0);
        check("t2_lfsr_checksum", checksum, 4'hE);
        run_burst(4'd0, 2'd1, 3, 0, -1, 0, 0, 1'b0);
        check("t2_lfsr0_checksum", checksum, 4'h7);

        // Three forced stall cycles after the second accept.
        run_burst(4'd0, 2'd0, 6, 0, 2, 3, 0, 1'b0);
        check("t3_stall", stall_cnt, 3);
        check("t3_words", words_sent, 6);
        check("t3_checksum", checksum, 4'h1);

        // Abort on the third accept.
        run_burst(4'd5, 2'd2, 8, 3, -1, 0, 0, 1'b0);
        check("t4_words", words_sent, 3);
        check("t4_aborted", aborted, 1);
        check("t4_checksum", checksum, 4'h5);

        // Zero-length burst clears the previous abort flag.
        run_burst(4'd7, 2'd3, 0, 0, -1, 0, 0, 1'b0);
        check("t5_words", words_sent, 0);
        check("t5_aborted", aborted, 0);

        // Start noise while busy, and stall counter saturation.
        run_burst(4'd9, 2'd3, 6, 0, -1, 0, 20, 1'b1);
        run_burst(4'd2, 2'd0, 2, 0, 1, 270, 0, 1'b0);
        check("sat_stall", stall_cnt, 255);

        // Randomized bursts.
        repeat (25) begin
            m   = $urandom % 4;
            s   = $urandom % 16;
            len = $urandom_range(15);
            ab  = (len > 0 && $urandom % 4 == 0) ? $urandom_range(len, 1) : 0;
            run_burst(4'(s), 2'(m), len, ab, -1, 0, 30, 1'b1);
        end

        // Asynchronous reset mid-burst, then a clean burst.
        @(negedge w_clk);
        start = 1'b1; burst_len = 4'd10; seed = 4'd4; mode = 2'd0; full = 1'b0;
        @(negedge w_clk);
        start = 1'b0;
        repeat (3) @(negedge w_clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_wr_rq", wr_rq, 0);
        check("mid_rst_wdata", wdata, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_aborted", aborted, 0);
        check("mid_rst_words", words_sent, 0);
        check("mid_rst_checksum", checksum, 0);
        check("mid_rst_stall", stall_cnt, 0);
        @(negedge w_clk);
        rst_n = 1'b1;
        run_burst(4'd6, 2'd1, 5, 0, -1, 0, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
